// File: rtl/mux_4to1_rr_pkg.sv
// rtl/mux_4to1_rr_pkg.sv - shared constants and state encoding for the 4-to-1 round-robin mux
package mux_4to1_rr_pkg;

    localparam int NUM_CH    = 4;
    localparam int SEL_W     = 2;
    localparam int DEF_WIDTH = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - combinational 4-way round-robin grant starting the search at ptr
module rr_arbiter_4
    import mux_4to1_rr_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_CH-1:0] gnt_onehot,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_any
);

    // Walk ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first requester found wins.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_any    = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!gnt_any && req[SEL_W'(ptr + SEL_W'(k))]) begin
                gnt_any    = 1'b1;
                gnt_idx    = SEL_W'(ptr + SEL_W'(k));
                gnt_onehot = NUM_CH'(1) << SEL_W'(ptr + SEL_W'(k));
            end
        end
    end

endmodule

// File: rtl/mux_4to1_rr.sv
// rtl/mux_4to1_rr.sv - 4-to-1 round-robin stream mux with a one-beat registered output stage
module mux_4to1_rr
    import mux_4to1_rr_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    out_ready
);

    state_t             r_state;
    state_t             w_next_state;
    logic [SEL_W-1:0]   r_ptr;
    logic [WIDTH-1:0]   r_data;
    logic [SEL_W-1:0]   r_sel;

    logic [NUM_CH-1:0]  w_gnt_onehot;
    logic [SEL_W-1:0]   w_gnt_idx;
    logic               w_gnt_any;
    logic               w_load_en;
    logic               w_in_xfer;
    logic [WIDTH-1:0]   w_gnt_data;

    rr_arbiter_4 u_arb (
        .req        (in_valid),
        .ptr        (r_ptr),
        .gnt_onehot (w_gnt_onehot),
        .gnt_idx    (w_gnt_idx),
        .gnt_any    (w_gnt_any)
    );

    // The output stage can take a beat when it is empty or is being drained this cycle;
    // reset blocks any input transfer so nothing is accepted while it is asserted.
    assign w_load_en  = (r_state == EMPTY) || out_ready;
    assign w_in_xfer  = w_gnt_any && w_load_en && !reset;
    assign w_gnt_data = in_data[w_gnt_idx*WIDTH +: WIDTH];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: a new beat always refills the stage; otherwise a drain empties it.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            EMPTY: begin
                if (w_in_xfer) w_next_state = FULL;
            end
            FULL: begin
                if (w_in_xfer)      w_next_state = FULL;
                else if (out_ready) w_next_state = EMPTY;
            end
            default: w_next_state = EMPTY;
        endcase
    end

    // Outputs: valid only when holding a beat; ready only toward the granted channel.
    always_comb begin
        out_valid = (r_state == FULL);
        in_ready  = '0;
        if (!reset && w_load_en) in_ready = w_gnt_onehot;
    end

    // Round-robin pointer advances past the channel just served, and only then.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_in_xfer) begin
            r_ptr <= w_gnt_idx + SEL_W'(1);
        end
    end

    // Output register captures the granted payload and its source channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
            r_sel  <= '0;
        end else if (w_in_xfer) begin
            r_data <= w_gnt_data;
            r_sel  <= w_gnt_idx;
        end
    end

    assign out_data = r_data;
    assign out_sel  = r_sel;

endmodule
